// File: rtl/hvac_pkg.sv
// rtl/hvac_pkg.sv - shared types and constants for the climate-control sequencer
//
// Purpose: state encoding, temperature width, frost threshold and the
// setpoint clamp helper used by hvac_sequencer.
// Optional feature macro consumed elsewhere: FROST_PROTECT_EN.
package hvac_pkg;

  localparam int TEMP_W   = 5;
  localparam int TEMP_MAX = (1 << TEMP_W) - 1;

  // Temperatures at or below this value count as frost danger.
  localparam logic [TEMP_W-1:0] FROST_TEMP = TEMP_W'(4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAT = 2'd1,
    COOL = 2'd2,
    LOCK = 2'd3
  } state_t;

  // Keeps the setpoint inside [lo, hi] so sp +/- hysteresis never leaves 0..31.
  function automatic logic [TEMP_W-1:0] clamp_setpoint(
    input logic [TEMP_W-1:0] value,
    input logic [TEMP_W-1:0] lo,
    input logic [TEMP_W-1:0] hi
  );
    if (value < lo) begin
      return lo;
    end else if (value > hi) begin
      return hi;
    end
    return value;
  endfunction

endpackage

// File: rtl/hvac_timer.sv
// rtl/hvac_timer.sv - clearable saturating up-counter with terminal-count compare
//
// Purpose: shared episode timer; counts up each cycle until it reaches i_tc,
// then holds. i_clear has priority over counting.
// Ports:
//   i_clk    in  1  clock, rising edge
//   i_rst    in  1  asynchronous active-high reset
//   i_clear  in  1  synchronous clear to zero
//   i_tc     in  W  terminal count (saturation value)
//   o_at_tc  out 1  counter equals i_tc
module hvac_timer #(
  parameter int W = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clear,
  input  logic [W-1:0] i_tc,
  output logic         o_at_tc
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (r_count != i_tc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_at_tc = (r_count == i_tc);

endmodule

// File: rtl/hvac_sequencer.sv
// rtl/hvac_sequencer.sv - heating/cooling sequencer with hysteresis, min run and lockout
//
// Purpose: decides when heating or cooling is driven from the temperature and a
// programmable setpoint. Episodes last at least MIN_RUN cycles and are always
// followed by LOCKOUT cycles with both outputs off.
// Optional feature: define FROST_PROTECT_EN to force heating at or below the
// frost threshold regardless of i_enable.
// Ports:
//   i_clk            in  1  system clock, rising edge
//   i_rst            in  1  asynchronous active-high reset
//   i_enable         in  1  climate control enabled
//   i_temperature    in  5  current temperature, unsigned degrees
//   i_setpoint       in  5  new setpoint value
//   i_setpoint_load  in  1  one-cycle strobe capturing i_setpoint
//   o_heating        out 1  heater on
//   o_cooling        out 1  cooler on
//   o_state          out 2  0 IDLE, 1 HEAT, 2 COOL, 3 LOCK
//   o_locked         out 1  high while in LOCK
module hvac_sequencer
  import hvac_pkg::*;
#(
  parameter int HYST       = 2,
  parameter int MIN_RUN    = 8,
  parameter int LOCKOUT    = 4,
  parameter int SP_DEFAULT = 20
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic [TEMP_W-1:0] i_temperature,
  input  logic [TEMP_W-1:0] i_setpoint,
  input  logic              i_setpoint_load,
  output logic              o_heating,
  output logic              o_cooling,
  output logic [1:0]        o_state,
  output logic              o_locked
);

  localparam int RUN_MAX = (MIN_RUN > LOCKOUT) ? MIN_RUN : LOCKOUT;
  localparam int TW      = (RUN_MAX > 2) ? $clog2(RUN_MAX) : 1;

  localparam logic [TW-1:0]     RUN_TC  = TW'(MIN_RUN - 1);
  localparam logic [TW-1:0]     LOCK_TC = TW'(LOCKOUT - 1);
  localparam logic [TEMP_W-1:0] SP_LO   = TEMP_W'(HYST);
  localparam logic [TEMP_W-1:0] SP_HI   = TEMP_W'(TEMP_MAX - HYST);
  localparam logic [TEMP_W-1:0] SP_RST  = TEMP_W'(SP_DEFAULT);

  state_t            r_state;
  state_t            w_next_state;
  logic [TEMP_W-1:0] r_sp;

  logic [TEMP_W:0]   w_temp_ext;
  logic [TEMP_W:0]   w_lo;
  logic [TEMP_W:0]   w_hi;
  logic              w_cold;
  logic              w_hot;
  logic              w_frost;
  logic              w_timer_clear;
  logic [TW-1:0]     w_timer_tc;
  logic              w_at_tc;

  // One bit of headroom so sp +/- HYST can never wrap.
  assign w_temp_ext = {1'b0, i_temperature};
  assign w_lo       = {1'b0, r_sp} - (TEMP_W+1)'(HYST);
  assign w_hi       = {1'b0, r_sp} + (TEMP_W+1)'(HYST);
  assign w_cold     = (w_temp_ext < w_lo);
  assign w_hot      = (w_temp_ext > w_hi);

`ifdef FROST_PROTECT_EN
  assign w_frost = (i_temperature <= FROST_TEMP);
`else
  assign w_frost = 1'b0;
`endif

  // Setpoint register; same-cycle comparisons see the old value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sp <= SP_RST;
    end else if (i_setpoint_load) begin
      r_sp <= clamp_setpoint(i_setpoint, SP_LO, SP_HI);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if ((i_enable && w_cold) || w_frost) begin
          w_next_state = HEAT;
        end else if (i_enable && w_hot) begin
          w_next_state = COOL;
        end
      end
      HEAT: begin
        // Frost danger keeps the heater running through a disable.
        if ((!i_enable && !w_frost) || ((i_temperature >= r_sp) && w_at_tc)) begin
          w_next_state = LOCK;
        end
      end
      COOL: begin
        if (!i_enable || ((i_temperature <= r_sp) && w_at_tc)) begin
          w_next_state = LOCK;
        end
      end
      LOCK: begin
        if (w_at_tc) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // The single timer restarts on every state change, so each phase counts from
  // zero; it is held at zero while idle.
  assign w_timer_clear = (w_next_state != r_state) || (r_state == IDLE);
  assign w_timer_tc    = (r_state == LOCK) ? LOCK_TC : RUN_TC;

  hvac_timer #(
    .W (TW)
  ) u_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (w_timer_clear),
    .i_tc    (w_timer_tc),
    .o_at_tc (w_at_tc)
  );

  assign o_state   = r_state;
  assign o_heating = (r_state == HEAT);
  assign o_cooling = (r_state == COOL);
  assign o_locked  = (r_state == LOCK);

endmodule

// File: doc/hvac_sequencer.md
Name: hvac_sequencer

Overview:
- Climate-control sequencer for the smart-home design.
- Takes the 5-bit temperature reading and a programmable setpoint, and decides when the heating and cooling outputs are driven.
- Applies a hysteresis band, a minimum run time and a compressor lockout so the actuators never chatter and are never both on.
- Sits between the temperature input path and the heating/cooling outputs of the top-level smart-home block.

Parameters:
- HYST, 2: hysteresis half-band in degrees (temperature LSBs).
- MIN_RUN, 8: minimum number of clk cycles a HEAT or COOL episode lasts.
- LOCKOUT, 4: number of clk cycles both outputs are forced off after any episode.
- SP_DEFAULT, 20: setpoint value loaded at reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  climate control enabled.
- temperature  in  5  current temperature, unsigned degrees.
- setpoint  in  5  new setpoint value.
- setpoint_load  in  1  one-cycle strobe; captures setpoint.
- heating  out  1  heater on.
- cooling  out  1  cooler on.
- state  out  2  current FSM state: 0 IDLE, 1 HEAT, 2 COOL, 3 LOCK.
- locked  out  1  high while in LOCK.

Behaviour:
- Reset (async, rst=1): state=IDLE, heating=0, cooling=0, locked=0, timer=0, sp_reg=SP_DEFAULT. All outputs drop without waiting for a clock edge.
- All outputs are registered and are decoded from the state register. heating is 1 iff state=HEAT; cooling is 1 iff state=COOL.
- Setpoint capture:
  - setpoint_load=1 latches the clamped value into sp_reg at the clock edge.
  - Clamp range is [HYST, 31-HYST].
  - Comparisons in the same cycle as the load use the old sp_reg.
- Arithmetic:
  - Thresholds lo = sp_reg - HYST and hi = sp_reg + HYST are computed at 6 bits unsigned, so there is no wrap.
  - The clamp guarantees 0 <= lo and hi <= 31.
- IDLE:
  - enable=1 and temperature < lo -> HEAT. timer is cleared.
  - enable=1 and temperature > hi -> COOL. timer is cleared.
  - Otherwise stay in IDLE.
  - The two conditions are mutually exclusive.
- Latency: 1 clk from the sampled temperature to heating or cooling asserting.
- HEAT:
  - timer increments each cycle and saturates at MIN_RUN-1.
  - Go to LOCK when (temperature >= sp_reg and timer == MIN_RUN-1) or enable=0. timer is cleared on entry to LOCK.
  - enable=0 exits on the next edge, regardless of timer.
- COOL:
  - Mirrors HEAT; the exit condition is temperature <= sp_reg.
- LOCK:
  - Both outputs are 0 and locked=1.
  - timer increments; go to IDLE when timer == LOCKOUT-1.
  - enable has no effect here.
  - A direct HEAT<->COOL transition is impossible.
- A temperature swing to the opposite side during an episode has no effect until the episode exits through LOCK.
- Invariant: heating & cooling is never 1.

Optional Feature:
- Macro: FROST_PROTECT_EN.
- When defined:
  - In IDLE, temperature <= 4 forces HEAT even when enable=0.
  - While in HEAT with temperature <= 4, the enable=0 exit is suppressed.
  - All other rules, including MIN_RUN and LOCK, are unchanged.
- When undefined: enable=0 always blocks entry to HEAT and COOL, and no frost logic is synthesized.

Decomposition:
- Package hvac_pkg holds:
  - the state encoding constants IDLE/HEAT/COOL/LOCK (2-bit);
  - the temperature width (5);
  - the frost threshold constant (4).
- One sub-module, hvac_timer: a clearable saturating up-counter with a terminal-count compare input. It is instantiated once and shared by the run and lockout phases.

Test Plan:
Defaults for all scenarios: HYST=2, MIN_RUN=8, LOCKOUT=4, SP_DEFAULT=20, enable=1.
1. Reset released, temperature=20 for 50 cycles -> state=IDLE, heating=0, cooling=0 throughout.
2. HEAT episode:
   - Stimulus: temperature=17, then 21 after 3 cycles.
   - heating=1 one edge after 17 is sampled, and stays 1 for exactly 8 cycles.
   - Then locked=1 with both outputs 0 for 4 cycles, then IDLE.
3. Reversal mid-episode:
   - Stimulus: temperature=23 -> COOL; at cycle 2 of COOL, temperature=10.
   - cooling holds, because the exit needs temperature <= 20 and MIN_RUN, so it exits on reaching MIN_RUN.
   - Then LOCK for 4 cycles, then HEAT.
   - heating and cooling are never high together.
4. Setpoint clamp:
   - setpoint=31 with load -> sp_reg=29; temperature=31 -> stays IDLE.
   - setpoint=0 with load -> sp_reg=2; temperature=0 -> stays IDLE.
5. enable=0 in HEAT at cycle 3 -> LOCK on the next edge (heating=0), then IDLE; no further HEAT while enable=0, even with temperature=10.
6. rst pulsed asynchronously between edges during COOL -> cooling=0 and state=0 immediately; after release, sp_reg=20.
